// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: A-source encodings, opcodes and default widths.
package cpu_pkg;

  localparam int unsigned DATA_W_DEFAULT = 8;
  localparam int unsigned ADDR_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    ASEL_ADD  = 2'b00,
    ASEL_IN   = 2'b01,
    ASEL_MEM  = 2'b10,
    ASEL_ZERO = 2'b11
  } asel_e;

  // Opcodes carried in IR[7:5], decoded by ControlUnit.
  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_IN    = 3'b100;
  localparam logic [2:0] OP_JZ    = 3'b101;
  localparam logic [2:0] OP_JPOS  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

endpackage

// File: rtl/cpu_datapath_if.sv
// Control strobes, host program-load port and status outputs between ControlUnit/host and
// the datapath.
interface cpu_datapath_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
);

  logic              IRload;
  logic              JMPmux;
  logic              PCload;
  logic              Meminst;
  logic              MemWr;
  logic              Aload;
  logic              Sub;
  logic [1:0]        Asel;
  logic [DATA_W-1:0] Input;
  logic              ProgWr;
  logic [ADDR_W-1:0] ProgAddr;
  logic [DATA_W-1:0] ProgData;
  logic [DATA_W-1:0] IR;
  logic              Aeq0;
  logic              Apos;
  logic [ADDR_W-1:0] PC;
  logic [DATA_W-1:0] Output;

  modport master (
    output IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, Input,
    output ProgWr, ProgAddr, ProgData,
    input  IR, Aeq0, Apos, PC, Output
  );

  modport slave (
    input  IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, Input,
    input  ProgWr, ProgAddr, ProgData,
    output IR, Aeq0, Apos, PC, Output
  );

endinterface

// File: rtl/dp_ram.sv
// Unified program/data RAM: async read, one sync write port where host ProgWr beats MemWr.
module dp_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [DATA_W-1:0] rdata_o,
  input  logic              mem_wr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              prog_wr_i,
  input  logic [ADDR_W-1:0] prog_addr_i,
  input  logic [DATA_W-1:0] prog_data_i
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  always_comb begin
    we    = prog_wr_i | mem_wr_i;
    waddr = prog_wr_i ? prog_addr_i : addr_i;
    wdata = prog_wr_i ? prog_data_i : wdata_i;
  end

  // Contents survive reset on purpose so a preloaded program can be re-run.
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/cpu_datapath.sv
// Accumulator CPU datapath: PC, IR, A, add/sub unit and unified RAM.
// Define CPU_DATAPATH_OUTREG_EN to register Output instead of mirroring A.
module cpu_datapath #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic         Clock,
  input  logic         Reset,
  cpu_datapath_if.slave bus
);

  import cpu_pkg::*;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] m;
  logic [DATA_W-1:0] sum;

  assign addr = bus.Meminst ? ir_q[ADDR_W-1:0] : pc_q;

  dp_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk_i      (Clock),
    .addr_i     (addr),
    .rdata_o    (m),
    .mem_wr_i   (bus.MemWr),
    .wdata_i    (a_q),
    .prog_wr_i  (bus.ProgWr),
    .prog_addr_i(bus.ProgAddr),
    .prog_data_i(bus.ProgData)
  );

  assign sum = bus.Sub ? (a_q - m) : (a_q + m);

  always_comb begin
    pc_d = pc_q;
    ir_d = ir_q;
    a_d  = a_q;
    if (bus.PCload) begin
      pc_d = bus.JMPmux ? ir_q[ADDR_W-1:0] : pc_q + 1'b1;
    end
    if (bus.IRload) begin
      ir_d = m;
    end
    if (bus.Aload) begin
      unique case (asel_e'(bus.Asel))
        ASEL_ADD:  a_d = sum;
        ASEL_IN:   a_d = bus.Input;
        ASEL_MEM:  a_d = m;
        ASEL_ZERO: a_d = '0;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc_q <= '0;
      ir_q <= '0;
      a_q  <= '0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
      a_q  <= a_d;
    end
  end

  assign bus.PC   = pc_q;
  assign bus.IR   = ir_q;
  assign bus.Aeq0 = (a_q == '0);
  assign bus.Apos = ~a_q[DATA_W-1];

`ifdef CPU_DATAPATH_OUTREG_EN
  logic [DATA_W-1:0] out_q;

  // Only arithmetic results and IN values are published on the output port.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      out_q <= '0;
    end else if (bus.Aload && (bus.Asel == ASEL_ADD || bus.Asel == ASEL_IN)) begin
      out_q <= a_d;
    end
  end

  assign bus.Output = out_q;
`else
  assign bus.Output = a_q;
`endif

endmodule
